// File: rtl/mips32_prog_loader.sv
// Boot-time program loader: unpacks a framed byte stream into 32-bit words, writes them
// into the core's MEM array and releases the core once the trailing checksum matches.
// Optional write readback check is enabled by defining LOADER_READBACK_EN.
module mips32_prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              cpu_run,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_VERIFY = 3'd4;
    localparam logic [2:0] S_CSUM   = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       MAX_N = 32'(MAX_WORDS);

    logic [2:0]        state_reg, state_next;
    logic [1:0]        byte_cnt_reg;
    logic [31:0]       sum_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   word_count_reg;
    logic [1:0]        err_code_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [31:0]       mem_wdata_reg;

    logic        xfer;
    logic        last_byte;
    logic        bad_count;
    logic        last_after_write;
    logic [31:0] word_full;

    assign xfer      = in_valid && in_ready;
    assign last_byte = xfer && (byte_cnt_reg == 2'd3);

    // Bytes 0..2 of the current word are captured in their own lanes; byte 3 is
    // taken straight from in_data so the complete word is usable on the 4th transfer.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_lane
            logic [7:0] byte_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    byte_reg <= '0;
                end else if (xfer && (byte_cnt_reg == 2'(gi))) begin
                    byte_reg <= in_data;
                end
            end
        end
    endgenerate

    assign word_full = {g_lane[0].byte_reg, g_lane[1].byte_reg, g_lane[2].byte_reg, in_data};
    assign bad_count = (word_full == 32'd0) || (word_full > MAX_N);
    assign last_after_write = ((word_count_reg + 1'b1) == count_reg);

`ifdef LOADER_READBACK_EN
    logic verify_cnt_reg;
    logic readback_bad;

    assign readback_bad = (mem_rdata != mem_wdata_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            verify_cnt_reg <= 1'b0;
        end else begin
            verify_cnt_reg <= (state_reg == S_VERIFY) && !verify_cnt_reg;
        end
    end
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_HDR;
            S_HDR:    if (last_byte) state_next = bad_count ? S_ERR : S_DATA;
            S_DATA:   if (last_byte) state_next = S_WRITE;
`ifdef LOADER_READBACK_EN
            S_WRITE:  state_next = S_VERIFY;
            S_VERIFY: begin
                if (verify_cnt_reg) begin
                    if (readback_bad) begin
                        state_next = S_ERR;
                    end else begin
                        // word_count already advanced during WRITE
                        state_next = (word_count_reg == count_reg) ? S_CSUM : S_DATA;
                    end
                end
            end
`else
            S_WRITE:  state_next = last_after_write ? S_CSUM : S_DATA;
`endif
            S_CSUM:   if (last_byte) state_next = (word_full == sum_reg) ? S_DONE : S_ERR;
            S_DONE:   if (start) state_next = S_HDR;
            S_ERR:    if (start) state_next = S_HDR;
            default:  state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            byte_cnt_reg   <= '0;
            sum_reg        <= '0;
            count_reg      <= '0;
            word_count_reg <= '0;
            err_code_reg   <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
        end else begin
            state_reg <= state_next;
            if (xfer) begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
            case (state_reg)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        byte_cnt_reg   <= '0;
                        sum_reg        <= '0;
                        word_count_reg <= '0;
                        err_code_reg   <= 2'b00;
                    end
                end
                S_HDR: begin
                    if (last_byte) begin
                        count_reg      <= word_full[ADDR_W:0];
                        sum_reg        <= '0;
                        word_count_reg <= '0;
                        if (bad_count) begin
                            err_code_reg <= 2'b01;
                        end
                    end
                end
                S_DATA: begin
                    if (last_byte) begin
                        mem_addr_reg  <= BASE + word_count_reg[ADDR_W-1:0];
                        mem_wdata_reg <= word_full;
                    end
                end
                S_WRITE: begin
                    sum_reg        <= sum_reg + mem_wdata_reg;
                    word_count_reg <= word_count_reg + 1'b1;
                end
`ifdef LOADER_READBACK_EN
                S_VERIFY: begin
                    if (verify_cnt_reg && readback_bad) begin
                        err_code_reg <= 2'b11;
                    end
                end
`endif
                S_CSUM: begin
                    if (last_byte && (word_full != sum_reg)) begin
                        err_code_reg <= 2'b10;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = (state_reg == S_HDR) || (state_reg == S_DATA) || (state_reg == S_CSUM);
    assign busy       = in_ready || (state_reg == S_WRITE) || (state_reg == S_VERIFY);
    assign mem_we     = (state_reg == S_WRITE);
    assign done       = (state_reg == S_DONE);
    assign cpu_run    = (state_reg == S_DONE);
    assign error      = (state_reg == S_ERR);
    assign err_code   = err_code_reg;
    assign word_count = word_count_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Scoreboard bench: two loaders (BASE_ADDR 0 and 1023) share one byte stream; expected
// writes and final status are queued by the stimulus and popped by a negedge monitor.
module tb_mips32_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid;
    logic [7:0] in_data;
    logic       corrupt;

    logic        in_ready0, mem_we0, busy0, done0, error0, cpu_run0;
    logic [9:0]  mem_addr0;
    logic [31:0] mem_wdata0, rdata0;
    logic [1:0]  err_code0;
    logic [10:0] word_count0;

    logic        in_ready1, mem_we1, busy1, done1, error1, cpu_run1;
    logic [9:0]  mem_addr1;
    logic [31:0] mem_wdata1, rdata1;
    logic [1:0]  err_code1;
    logic [10:0] word_count1;

    mips32_prog_loader dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(rdata0), .busy(busy0), .done(done0), .error(error0), .err_code(err_code0),
        .cpu_run(cpu_run0), .word_count(word_count0)
    );

    mips32_prog_loader #(.BASE_ADDR(1023)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(rdata1), .busy(busy1), .done(done1), .error(error1), .err_code(err_code1),
        .cpu_run(cpu_run1), .word_count(word_count1)
    );

    // Memory models with registered read; corrupt forces 0 on the 2nd word's readback.
    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];
    always @(posedge clk) begin
        if (mem_we0) mem0[mem_addr0] <= mem_wdata0;
        if (mem_we1) mem1[mem_addr1] <= mem_wdata1;
        rdata0 <= (corrupt && mem_addr0 == 10'd1) ? 32'd0 : mem0[mem_addr0];
        rdata1 <= (corrupt && mem_addr1 == 10'd0) ? 32'd0 : mem1[mem_addr1];
    end

    int checks = 0;
    int errors = 0;

    logic [41:0] exw0 [$];
    logic [41:0] exw1 [$];
    logic [15:0] exs0 [$];
    logic [15:0] exs1 [$];

    logic [31:0] frame [8];
    int          frame_len;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected write per mem_we cycle and one status per done/error rise.
    logic prev0 = 1'b0, prev1 = 1'b0;
    always @(negedge clk) begin
        logic [41:0] w;
        logic [15:0] s;
        if (mem_we0) begin
            if (exw0.size() == 0) check("unexpected_write0", {22'd0, mem_addr0, mem_wdata0}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin w = exw0.pop_front(); check("write0", {22'd0, mem_addr0, mem_wdata0}, {22'd0, w}); end
        end
        if (mem_we1) begin
            if (exw1.size() == 0) check("unexpected_write1", {22'd0, mem_addr1, mem_wdata1}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin w = exw1.pop_front(); check("write1", {22'd0, mem_addr1, mem_wdata1}, {22'd0, w}); end
        end
        if ((done0 || error0) && !prev0) begin
            if (exs0.size() == 0) check("unexpected_status0", {48'd0, done0, error0, err_code0, cpu_run0, word_count0}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin s = exs0.pop_front(); check("status0", {48'd0, done0, error0, err_code0, cpu_run0, word_count0}, {48'd0, s}); end
        end
        if ((done1 || error1) && !prev1) begin
            if (exs1.size() == 0) check("unexpected_status1", {48'd0, done1, error1, err_code1, cpu_run1, word_count1}, 64'hFFFF_FFFF_FFFF_FFFF);
            else begin s = exs1.pop_front(); check("status1", {48'd0, done1, error1, err_code1, cpu_run1, word_count1}, {48'd0, s}); end
        end
        prev0 = done0 || error0;
        prev1 = done1 || error1;
    end

    task automatic expect_writes(input int n);
        for (int i = 0; i < n; i++) begin
            exw0.push_back({10'(i), frame[i+1]});
            exw1.push_back({10'(1023 + i), frame[i+1]});
        end
    endtask

    task automatic expect_status(input logic d, input logic e, input logic [1:0] c, input logic r, input logic [10:0] wc);
        exs0.push_back({d, e, c, r, wc});
        exs1.push_back({d, e, c, r, wc});
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 0;
        in_valid = 1'b0;
        if (gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (in_ready0) got = 1;
            @(posedge clk); #1;
        end
        if (!got) check("byte_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int max_gap);
        logic [31:0] w;
        for (int k = 0; k < frame_len; k++) begin
            w = frame[k];
            for (int b = 0; b < 4; b++) begin
                send_byte(w[31-8*b -: 8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_flag(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done0 || error0) return;
        end
        check({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_reset(input string name);
        check({name, "0"}, {3'd0, busy0, in_ready0, mem_we0, mem_addr0, mem_wdata0, done0, error0, err_code0, cpu_run0, word_count0}, 64'd0);
        check({name, "1"}, {3'd0, busy1, in_ready1, mem_we1, mem_addr1, mem_wdata1, done1, error1, err_code1, cpu_run1, word_count1}, 64'd0);
    endtask

    task automatic load_good_frame();
        frame[0] = 32'd2;
        frame[1] = 32'h2801_0005;
        frame[2] = 32'h2802_000A;
        frame[3] = 32'h5003_000F;
        frame_len = 4;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0; corrupt = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_reset("reset_state");

        // normal load, valid held high
        load_good_frame();
        expect_writes(2);
        expect_status(1'b1, 1'b0, 2'b00, 1'b1, 11'd2);
        pulse_start();
        send_frame(0);
        wait_flag("normal");

        // checksum off by one
        frame[3] = 32'h5003_000E;
        expect_writes(2);
        expect_status(1'b0, 1'b1, 2'b10, 1'b0, 11'd2);
        pulse_start();
        send_frame(0);
        wait_flag("bad_csum");

        // zero count
        frame[0] = 32'd0; frame_len = 1;
        expect_status(1'b0, 1'b1, 2'b01, 1'b0, 11'd0);
        pulse_start();
        send_frame(0);
        wait_flag("count_zero");

        // count one beyond MAX_WORDS
        frame[0] = 32'h0000_0401; frame_len = 1;
        expect_status(1'b0, 1'b1, 2'b01, 1'b0, 11'd0);
        pulse_start();
        send_frame(0);
        wait_flag("count_big");

        // normal load with 0-3 cycle valid gaps
        load_good_frame();
        expect_writes(2);
        expect_status(1'b1, 1'b0, 2'b00, 1'b1, 11'd2);
        pulse_start();
        send_frame(3);
        wait_flag("gapped");

        // reset right after the first payload word is written
        load_good_frame();
        frame_len = 2;
        expect_writes(1);
        pulse_start();
        send_frame(0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset("mid_load_reset");
        load_good_frame();
        expect_writes(2);
        expect_status(1'b1, 1'b0, 2'b00, 1'b1, 11'd2);
        pulse_start();
        send_frame(0);
        wait_flag("after_reset");

`ifdef LOADER_READBACK_EN
        // readback of the 2nd word returns 0
        load_good_frame();
        frame_len = 3;
        corrupt = 1'b1;
        expect_writes(2);
        expect_status(1'b0, 1'b1, 2'b11, 1'b0, 11'd2);
        pulse_start();
        send_frame(0);
        wait_flag("readback");
        corrupt = 1'b0;
`endif

        repeat (5) @(posedge clk);
        check("leftover_writes0", 64'(exw0.size()), 64'd0);
        check("leftover_writes1", 64'(exw1.size()), 64'd0);
        check("leftover_status0", 64'(exs0.size()), 64'd0);
        check("leftover_status1", 64'(exs1.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
